sram_port_arbiter: RTL

- Shares one synchronous single-port SRAM between instruction fetch (IF) and the memory stage (data side).
- Sits between the fetch/mem pipeline stages and the physical SRAM.
- Sequences exactly one outstanding transaction at a time using req/addr_ok/data_ok handshakes.
- Raises a stall request that the pipeline stall controller uses to build the stall vector.

---
 rtl/sram_port_arbiter_if.sv | 46 ++++
 rtl/sram_port_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the fetch/mem stages, the SRAM and the port arbiter.
// The arbiter takes the slave view; the pipeline-plus-SRAM environment takes the master view.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        mem_stall_req;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  sram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    output mem_stall_req
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output sram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    input  mem_stall_req
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and the data side,
// with one transaction in flight, a data-first priority and a bounded IF starvation count.
module sram_port_arbiter #(
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 2
) (
  input logic                  clk_i,
  input logic                  reset_i,
  input logic                  flush_i,
  sram_port_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;
  typedef enum logic [1:0] {OwnNone, OwnInst, OwnData} owner_e;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  starve_q, starve_d;
  logic        squash_q, squash_d;

  logic complete;
  logic grant_pt;
  logic grant_inst;
  logic grant_data;

  assign complete   = (state_q == StBusy) && (cnt_q == 3'd1);
  assign grant_pt   = (state_q == StIdle) || complete;
  // Data normally wins; a saturated starve count hands the slot to IF instead.
  assign grant_data = ~reset_i & grant_pt & bus.data_req &
                      (~bus.inst_req | (starve_q != StarveMax));
  assign grant_inst = ~reset_i & grant_pt & bus.inst_req & ~grant_data;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    squash_d = squash_q;

    if (state_q == StBusy) begin
      cnt_d = cnt_q - 3'd1;
      if (complete) begin
        state_d  = StIdle;
        owner_d  = OwnNone;
        squash_d = 1'b0;
      end else if (owner_q == OwnInst && flush_i) begin
        squash_d = 1'b1;
      end
    end

    if (grant_data || grant_inst) begin
      state_d  = StBusy;
      owner_d  = grant_data ? OwnData : OwnInst;
      cnt_d    = 3'(LAT);
      squash_d = grant_inst & flush_i;
    end

    if (!bus.inst_req || grant_inst) begin
      starve_d = '0;
    end else if (grant_data && starve_q < StarveMax) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      owner_q  <= OwnNone;
      cnt_q    <= '0;
      starve_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      squash_q <= squash_d;
    end
  end

  // A flushed IF transaction still occupies the port until its count expires.
  assign bus.inst_data_ok  = ~reset_i & complete & (owner_q == OwnInst) & ~squash_q & ~flush_i;
  assign bus.data_data_ok  = ~reset_i & complete & (owner_q == OwnData);
  assign bus.inst_addr_ok  = grant_inst;
  assign bus.data_addr_ok  = grant_data;
  assign bus.inst_rdata    = bus.inst_data_ok ? bus.sram_rdata : '0;
  assign bus.data_rdata    = bus.data_data_ok ? bus.sram_rdata : '0;

  assign bus.sram_en       = grant_inst | grant_data;
  assign bus.sram_we       = (grant_data && bus.data_wr) ? bus.data_wstrb : 4'b0000;
  assign bus.sram_addr     = grant_data ? bus.data_addr :
                             grant_inst ? bus.inst_addr : '0;
  assign bus.sram_wdata    = bus.sram_en ? bus.data_wdata : '0;

  assign bus.mem_stall_req = ~reset_i & bus.data_req & ~bus.data_data_ok;

endmodule
